tdes_pass_sequencer: RTL and testbench

TDES_PASS_SEQUENCER -- requirements
Module: tdes_pass_sequencer

---
 rtl/tdes_pass_sequencer_if.sv | 48 ++++
 rtl/tdes_pass_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_tdes_pass_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdes_pass_sequencer_if.sv
// ---------------------------------------------------------------------------
// tdes_pass_sequencer_if
// Bundles the block-request handshake, the shared single-DES core hookup,
// the result handshake and the status flags of tdes_pass_sequencer.
//   slave  : the sequencer's view (accepts blocks, drives the core, returns
//            results, reports status)
//   master : the surrounding system's view (offers blocks, hosts the DES
//            core, consumes results)
// ---------------------------------------------------------------------------
interface tdes_pass_sequencer_if;
  // block request
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        enc_dec;
  logic [63:0] key1;
  logic [63:0] key2;
  logic [63:0] key3;
  // shared single-DES core
  logic        des_start;
  logic        des_mode;
  logic [63:0] des_key;
  logic [63:0] des_din;
  logic        des_done;
  logic [63:0] des_dout;
  // result
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  // status
  logic        busy;
  logic [1:0]  pass_cnt;
  logic        err;

  modport slave (
    input  in_valid, in_data, enc_dec, key1, key2, key3,
    input  des_done, des_dout, out_ready,
    output in_ready, des_start, des_mode, des_key, des_din,
    output out_valid, out_data, busy, pass_cnt, err
  );

  modport master (
    output in_valid, in_data, enc_dec, key1, key2, key3,
    output des_done, des_dout, out_ready,
    input  in_ready, des_start, des_mode, des_key, des_din,
    input  out_valid, out_data, busy, pass_cnt, err
  );
endinterface

// File: rtl/tdes_pass_sequencer.sv
// ---------------------------------------------------------------------------
// tdes_pass_sequencer
// Runs one 64-bit block through three passes of a shared single-DES core to
// form Triple-DES (EDE). Encrypt uses E/key1, D/key2, E/key3; decrypt uses
// D/key3, E/key2, D/key1. Inputs are captured on acceptance, so the caller
// may change them while the operation runs. A watchdog aborts a pass whose
// core never answers and raises a sticky err flag.
// Ports:
//   HCLK    : clock, rising edge
//   HRESET  : synchronous active-low reset
//   bus     : tdes_pass_sequencer_if.slave
//             in_valid/in_ready/in_data/enc_dec/key1..3 : block request
//             des_start/des_mode/des_key/des_din        : core command
//             des_done/des_dout                         : core response
//             out_valid/out_ready/out_data              : result handshake
//             busy/pass_cnt/err                         : status
// ---------------------------------------------------------------------------
module tdes_pass_sequencer (
  input  logic                  HCLK,
  input  logic                  HRESET,
  tdes_pass_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [1:0] LAST_PASS = 2'd2;
  // The counter reaches 255 on the update made while it holds 254, i.e. on
  // the 255th WAIT cycle without a completion.
  localparam logic [7:0] WDOG_LAST = 8'd254;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic [63:0] blkLatch;
  logic [63:0] key1Latch;
  logic [63:0] key2Latch;
  logic [63:0] key3Latch;
  logic        encDecLatch;
  logic [63:0] workReg;
  logic [63:0] outData;
  logic [1:0]  passCnt;
  logic        errFlag;
  logic [7:0]  wdog;
  logic [63:0] desDin;

  // Core direction for a pass: EDE for encrypt, DED for decrypt.
  function automatic logic passMode(input logic encDec, input logic [1:0] pc);
    passMode = encDec ^ pc[0];
  endfunction

  // Core key for a pass: decrypt walks the key list in reverse order.
  function automatic logic [63:0] passKey(input logic encDec, input logic [1:0] pc,
                                          input logic [63:0] k1, input logic [63:0] k2,
                                          input logic [63:0] k3);
    case (pc)
      2'd0:    passKey = encDec ? k1 : k3;
      2'd1:    passKey = k2;
      2'd2:    passKey = encDec ? k3 : k1;
      default: passKey = 64'd0;
    endcase
  endfunction

  // Next-state decode for the pass sequencer.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          nextState = START;
        end else begin
          nextState = IDLE;
        end
      end
      START: begin
        nextState = WAIT;
      end
      WAIT: begin
        // A completion arriving on the last watchdog cycle still wins.
        if (bus.des_done) begin
          if (passCnt == LAST_PASS) begin
            nextState = HOLD;
          end else begin
            nextState = START;
          end
        end else if (wdog == WDOG_LAST) begin
          nextState = IDLE;
        end else begin
          nextState = WAIT;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          nextState = IDLE;
        end else begin
          nextState = HOLD;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register plus input capture, pass counting, result and watchdog.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state       <= IDLE;
      blkLatch    <= 64'd0;
      key1Latch   <= 64'd0;
      key2Latch   <= 64'd0;
      key3Latch   <= 64'd0;
      encDecLatch <= 1'b0;
      workReg     <= 64'd0;
      outData     <= 64'd0;
      passCnt     <= 2'd0;
      errFlag     <= 1'b0;
      wdog        <= 8'd0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            blkLatch    <= bus.in_data;
            key1Latch   <= bus.key1;
            key2Latch   <= bus.key2;
            key3Latch   <= bus.key3;
            encDecLatch <= bus.enc_dec;
            passCnt     <= 2'd0;
            errFlag     <= 1'b0;
          end
        end
        START: begin
          wdog <= 8'd0;
        end
        WAIT: begin
          wdog <= wdog + 8'd1;
          if (bus.des_done) begin
            workReg <= bus.des_dout;
            if (passCnt == LAST_PASS) begin
              outData <= bus.des_dout;
            end else begin
              passCnt <= passCnt + 2'd1;
            end
          end else if (wdog == WDOG_LAST) begin
            errFlag <= 1'b1;
          end
        end
        HOLD: begin
          outData <= outData;
        end
        default: begin
          wdog <= 8'd0;
        end
      endcase
    end
  end

  // Core data: the captured block feeds pass 0, the previous result feeds
  // passes 1 and 2. Both sources only change outside START/WAIT of a pass.
  always_comb begin
    if (passCnt == 2'd0) begin
      desDin = blkLatch;
    end else begin
      desDin = workReg;
    end
  end

  assign bus.in_ready  = HRESET && (state == IDLE);
  assign bus.des_start = (state == START);
  assign bus.des_mode  = passMode(encDecLatch, passCnt);
  assign bus.des_key   = passKey(encDecLatch, passCnt, key1Latch, key2Latch, key3Latch);
  assign bus.des_din   = desDin;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = outData;
  assign bus.busy      = (state != IDLE);
  assign bus.pass_cnt  = passCnt;
  assign bus.err       = errFlag;

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Bench for tdes_pass_sequencer: a table of fixed vectors, hand-written
// backpressure / back-to-back / watchdog / reset sequences and randomized
// transactions against a schedule-level reference model. The DES core is
// modelled as des_din ^ des_key with a programmable completion latency.
module tb_tdes_pass_sequencer;

  logic HCLK;
  logic HRESET;
  tdes_pass_sequencer_if bus ();

  tdes_pass_sequencer dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [63:0] data;
    logic [63:0] k1;
    logic [63:0] k2;
    logic [63:0] k3;
    logic        ed;
    logic [63:0] expOut;
  } vec_t;

  typedef struct {
    int          cyc;
    int          lat;
    logic        mode;
    logic [1:0]  pc;
    logic [63:0] key;
    logic [63:0] din;
  } start_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit suppress = 1'b0;
  bit randLat = 1'b0;
  start_t sLog[$];

  // core model state
  bit pend = 1'b0;
  int cnt = 0;
  logic [63:0] pval = 64'd0;

  always @(posedge HCLK) cyc = cyc + 1;

  // DES core model: result = din ^ key, done pulse 'lat' cycles after start.
  always @(negedge HCLK) begin
    start_t e;
    bus.des_done = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pend = 1'b0;
        if (!suppress) begin
          bus.des_done = 1'b1;
          bus.des_dout = pval;
        end
      end
    end
    if (bus.des_start === 1'b1) begin
      e.cyc  = cyc;
      e.lat  = randLat ? int'($urandom_range(1, 6)) : 3;
      e.mode = bus.des_mode;
      e.pc   = bus.pass_cnt;
      e.key  = bus.des_key;
      e.din  = bus.des_din;
      sLog.push_back(e);
      pend = 1'b1;
      cnt  = e.lat;
      pval = bus.des_din ^ bus.des_key;
    end
  end

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Schedule of a 3DES-EDE operation: mode and key of each pass.
  task automatic schedule(input logic ed, input logic [63:0] k1, input logic [63:0] k2,
                          input logic [63:0] k3, output logic m[3], output logic [63:0] k[3]);
    if (ed) begin
      m[0] = 1'b1; m[1] = 1'b0; m[2] = 1'b1;
      k[0] = k1;   k[1] = k2;   k[2] = k3;
    end else begin
      m[0] = 1'b0; m[1] = 1'b1; m[2] = 1'b0;
      k[0] = k3;   k[1] = k2;   k[2] = k1;
    end
  endtask

  // Reference result: feed the block through the three scheduled passes.
  function automatic logic [63:0] refResult(input logic ed, input logic [63:0] d,
                                            input logic [63:0] k1, input logic [63:0] k2,
                                            input logic [63:0] k3);
    logic [63:0] x;
    logic [63:0] ks[3];
    x = d;
    if (ed) begin
      ks[0] = k1; ks[1] = k2; ks[2] = k3;
    end else begin
      ks[0] = k3; ks[1] = k2; ks[2] = k1;
    end
    for (int i = 0; i < 3; i++) x = x ^ ks[i];
    return x;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full operation starting from IDLE; hold = extra cycles of backpressure.
  task automatic runTxn(input logic [63:0] d, input logic [63:0] k1, input logic [63:0] k2,
                        input logic [63:0] k3, input logic ed, input logic [63:0] expOut,
                        input int hold);
    int base;
    int n;
    int irBad;
    int holdBad;
    int expLat;
    logic [63:0] first;
    logic em[3];
    logic [63:0] ek[3];
    logic [63:0] x;
    base = sLog.size();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.key1     = k1;
    bus.key2     = k2;
    bus.key3     = k3;
    bus.enc_dec  = ed;
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    step();
    // inputs changed after acceptance must not matter
    bus.in_valid = 1'b0;
    bus.in_data  = rnd64();
    bus.key1     = rnd64();
    bus.key2     = rnd64();
    bus.key3     = rnd64();
    bus.enc_dec  = ~ed;
    chk("err_clear", 64'(bus.err), 64'd0);
    n = 1;
    irBad = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      if (bus.in_ready !== 1'b0) irBad++;
      step();
      n++;
    end
    chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
    if (bus.out_valid !== 1'b1) return;
    chk("start_count", 64'(sLog.size()), 64'(base + 3));
    if (sLog.size() >= base + 3) begin
      expLat = 4 + sLog[base].lat + sLog[base + 1].lat + sLog[base + 2].lat;
      chk("latency", 64'(n), 64'(expLat));
      schedule(ed, k1, k2, k3, em, ek);
      x = d;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("pass%0d_mode", i), 64'(sLog[base + i].mode), 64'(em[i]));
        chk($sformatf("pass%0d_key", i), sLog[base + i].key, ek[i]);
        chk($sformatf("pass%0d_cnt", i), 64'(sLog[base + i].pc), 64'(i));
        chk($sformatf("pass%0d_din", i), sLog[base + i].din, x);
        x = x ^ ek[i];
      end
    end
    chk("out_data", bus.out_data, expOut);
    chk("ready_low_busy", 64'(irBad), 64'd0);
    first = bus.out_data;
    holdBad = 0;
    for (int h = 0; h < hold; h++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== first || bus.in_ready !== 1'b0 ||
          sLog.size() != base + 3)
        holdBad++;
    end
    if (hold > 0) chk("hold_stable", 64'(holdBad), 64'd0);
    bus.out_ready = 1'b1;
    chk("ready_in_hold", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_ready = 1'b0;
    chk("idle_after_hs", 64'(bus.out_valid), 64'd0);
    chk("ready_after_hs", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    vec_t vecs[6];
    int base;
    int hc;
    int n;
    int ovSeen;
    int postBad;
    logic [63:0] ka;
    logic [63:0] kb;
    logic [63:0] kc;
    logic [63:0] exp1;
    logic [63:0] exp2;

    // data ^ (three pass keys), worked by hand
    vecs[0] = '{64'h6666666666666666, 64'h4444444444444444, 64'h5555555555555555,
                64'h6666666666666666, 1'b1, 64'h1111111111111111};
    vecs[1] = '{64'h6666666666666666, 64'h4444444444444444, 64'h5555555555555555,
                64'h6666666666666666, 1'b0, 64'h1111111111111111};
    vecs[2] = '{64'h0000000000000000, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                64'h0000000000000000, 1'b1, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
                64'h0000000000000000, 1'b0, 64'h0000000000000000};
    vecs[4] = '{64'h9999999999999999, 64'h0000000000000000, 64'h0000000000000000,
                64'h0000000000000000, 1'b1, 64'h9999999999999999};
    vecs[5] = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h0000000000000000,
                64'h0000000000000000, 1'b0, 64'hFFFFFFFFFFFFFFFF};

    HRESET        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.enc_dec   = 1'b0;
    bus.key1      = 64'd0;
    bus.key2      = 64'd0;
    bus.key3      = 64'd0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_des_start", 64'(bus.des_start), 64'd0);
    HRESET = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // fixed vectors, core latency 3 -> 13 cycles acceptance to out_valid
    for (int i = 0; i < 6; i++)
      runTxn(vecs[i].data, vecs[i].k1, vecs[i].k2, vecs[i].k3, vecs[i].ed, vecs[i].expOut, 0);

    // backpressure: 10 cycles with out_ready low
    runTxn(64'h0F0F0F0F0F0F0F0F, 64'h1234567812345678, 64'h8765432187654321,
           64'hDEADBEEFCAFEF00D, 1'b1,
           refResult(1'b1, 64'h0F0F0F0F0F0F0F0F, 64'h1234567812345678,
                     64'h8765432187654321, 64'hDEADBEEFCAFEF00D), 10);

    // back-to-back with in_valid held high and out_ready always high
    ka = 64'h0123456789ABCDEF;
    kb = 64'h1111111111111111;
    kc = 64'h2222222222222222;
    exp1 = refResult(1'b1, 64'h9999999999999999, ka, kb, kc);
    exp2 = refResult(1'b1, 64'hAAAAAAAAAAAAAAAA, ka, kb, kc);
    base = sLog.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h9999999999999999;
    bus.key1 = ka; bus.key2 = kb; bus.key3 = kc; bus.enc_dec = 1'b1;
    step();
    bus.in_data = 64'hAAAAAAAAAAAAAAAA;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.in_ready !== 1'b0) n = n + 1000;
      step();
      n++;
    end
    chk("b2b_first_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_first_data", bus.out_data, exp1);
    chk("b2b_ready_hold", 64'(bus.in_ready), 64'd0);
    hc = cyc;
    step();
    chk("b2b_ready_idle", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("b2b_second_data", bus.out_data, exp2);
    step();
    bus.out_ready = 1'b0;
    chk("b2b_starts", 64'(sLog.size()), 64'(base + 6));
    if (sLog.size() >= base + 6) begin
      chk("b2b_first_din", sLog[base].din, 64'h9999999999999999);
      chk("b2b_second_din", sLog[base + 3].din, 64'hAAAAAAAAAAAAAAAA);
      chk("b2b_second_start_cyc", 64'(sLog[base + 3].cyc), 64'(hc + 2));
    end

    // watchdog: the core never answers
    suppress = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1357135713571357;
    step();
    bus.in_valid = 1'b0;
    chk("wd_start", 64'(bus.des_start), 64'd1);
    ovSeen = 0;
    for (int i = 1; i <= 254; i++) begin
      step();
      if (bus.out_valid !== 1'b0) ovSeen++;
    end
    step();
    chk("wd_err_before", 64'(bus.err), 64'd0);
    chk("wd_busy_before", 64'(bus.busy), 64'd1);
    step();
    chk("wd_err_set", 64'(bus.err), 64'd1);
    chk("wd_idle", 64'(bus.busy), 64'd0);
    chk("wd_in_ready", 64'(bus.in_ready), 64'd1);
    chk("wd_no_out_valid", 64'(ovSeen + int'(bus.out_valid)), 64'd0);
    suppress = 1'b0;
    step();
    chk("wd_err_sticky", 64'(bus.err), 64'd1);
    // next operation clears err (checked inside runTxn)
    runTxn(64'h2468246824682468, ka, kb, kc, 1'b0,
           refResult(1'b0, 64'h2468246824682468, ka, kb, kc), 0);

    // reset during the pass-1 WAIT
    base = sLog.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hC0FFEEC0FFEEC0FF;
    bus.key1 = ka; bus.key2 = kb; bus.key3 = kc; bus.enc_dec = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (sLog.size() < base + 2 && n < 50) begin
      step();
      n++;
    end
    chk("rst_reach_pass1", 64'(sLog.size()), 64'(base + 2));
    step();
    HRESET = 1'b0;
    step();
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_des_start", 64'(bus.des_start), 64'd0);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_out_data", bus.out_data, 64'd0);
    chk("mrst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
    chk("mrst_err", 64'(bus.err), 64'd0);
    chk("mrst_des_key", bus.des_key, 64'd0);
    chk("mrst_des_din", bus.des_din, 64'd0);
    HRESET = 1'b1;
    base = sLog.size();
    step();
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    postBad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0) postBad++;
      step();
    end
    chk("mrst_late_done_ignored", 64'(postBad), 64'd0);
    chk("mrst_no_start", 64'(sLog.size()), 64'(base));

    // randomized operations with random core latency and backpressure
    randLat = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [63:0] d;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [63:0] r3;
      logic        e;
      d  = rnd64();
      r1 = rnd64();
      r2 = rnd64();
      r3 = rnd64();
      e  = 1'($urandom_range(0, 1));
      runTxn(d, r1, r2, r3, e, refResult(e, d, r1, r2, r3), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
